// File: rtl/pcra_fetch_unit.sv
// pcra_fetch_unit: program-counter / return-address unit feeding pipeline stage 0.
// Latency: MemAddr/FetchValid are combinational from registers and inputs; counter updates take effect one cycle after the edge.
// Backpressure: none; a stage-2 bus request steals MemAddr for that cycle and drops FetchValid.
//
// Ports:
//   ClockIn, ResetIn_n      - clock, synchronous active-low reset
//   IncPCRA[1:0]            - [0] bump active counter, [1] bump inactive counter
//   PcraFlip                - swap active/inactive roles at the edge
//   BusRequest, BusAddr     - stage-2 owns the memory bus and supplies the address
//   FetchSurpress           - stage-1 fetch suppression
//   LoadInactive, LoadData  - load the inactive counter (jump/call target)
//   MemAddr, FetchValid     - memory address and "this is an instruction fetch" flag
//   ActivePc, InactivePc    - registered counter values
//   ActiveSel               - 0 = PCRA0 active, 1 = PCRA1 active
//   StatsClear, StallCount  - present only when PCRA_FETCH_STATS_EN is defined:
//                             saturating count of cycles with FetchValid=0
//
// Build option: define PCRA_FETCH_STATS_EN to add the stall statistics counter.

module pcra_fetch_unit #(
  parameter int                   AddrWidth   = 16,
  parameter logic [AddrWidth-1:0] ResetVector = '0
) (
  input  logic                 ClockIn,
  input  logic                 ResetIn_n,
  input  logic [1:0]           IncPCRA,
  input  logic                 PcraFlip,
  input  logic                 BusRequest,
  input  logic                 FetchSurpress,
  input  logic [AddrWidth-1:0] BusAddr,
  input  logic                 LoadInactive,
  input  logic [AddrWidth-1:0] LoadData,
`ifdef PCRA_FETCH_STATS_EN
  input  logic                 StatsClear,
  output logic [15:0]          StallCount,
`endif
  output logic [AddrWidth-1:0] MemAddr,
  output logic                 FetchValid,
  output logic [AddrWidth-1:0] ActivePc,
  output logic [AddrWidth-1:0] InactivePc,
  output logic                 ActiveSel
);

  // The counters are stored by role (active / inactive) rather than by
  // physical name (PCRA0 / PCRA1). ActiveSel records which physical counter
  // currently holds the active role, so a flip just swaps the two role
  // registers. This keeps ActivePc and InactivePc as pure register outputs.
  logic [AddrWidth-1:0] r_active_pc;
  logic [AddrWidth-1:0] r_inactive_pc;
  logic                 r_active_sel;

  logic [AddrWidth-1:0] w_active_nxt;
  logic [AddrWidth-1:0] w_inactive_nxt;

  // Same-cycle updates are computed against the pre-flip roles; the flip is
  // applied afterwards, so the incremented old active PC becomes the return
  // address and a loaded target becomes the new fetch PC.
  always_comb begin
    w_active_nxt = r_active_pc;
    if (IncPCRA[0]) begin
      w_active_nxt = r_active_pc + AddrWidth'(1);
    end

    w_inactive_nxt = r_inactive_pc;
    if (LoadInactive) begin
      w_inactive_nxt = LoadData;
    end else if (IncPCRA[1]) begin
      w_inactive_nxt = r_inactive_pc + AddrWidth'(1);
    end
  end

  always_ff @(posedge ClockIn) begin
    if (!ResetIn_n) begin
      r_active_pc   <= ResetVector;
      r_inactive_pc <= ResetVector;
      r_active_sel  <= 1'b0;
    end else begin
      if (PcraFlip) begin
        r_active_pc   <= w_inactive_nxt;
        r_inactive_pc <= w_active_nxt;
      end else begin
        r_active_pc   <= w_active_nxt;
        r_inactive_pc <= w_inactive_nxt;
      end
      r_active_sel <= r_active_sel ^ PcraFlip;
    end
  end

  // Increments are deliberately not gated by BusRequest/FetchValid here;
  // stage 0 is responsible for only requesting them when appropriate.
  assign MemAddr    = BusRequest ? BusAddr : r_active_pc;
  assign FetchValid = !BusRequest && !FetchSurpress;
  assign ActivePc   = r_active_pc;
  assign InactivePc = r_inactive_pc;
  assign ActiveSel  = r_active_sel;

`ifdef PCRA_FETCH_STATS_EN
  logic [15:0] r_stall_cnt;

  // Clear wins over counting; the count sticks at all-ones rather than wrapping.
  always_ff @(posedge ClockIn) begin
    if (!ResetIn_n) begin
      r_stall_cnt <= 16'h0000;
    end else if (StatsClear) begin
      r_stall_cnt <= 16'h0000;
    end else if (!FetchValid && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign StallCount = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pcra_fetch_unit.sv
// tb_pcra_fetch_unit: directed self-checking bench for pcra_fetch_unit.
// Expected values are queued when each step is driven and popped after the step executes.
// Combinational outputs are checked before the edge, registered outputs 1ns after it.

module tb_pcra_fetch_unit;

  logic        ClockIn = 1'b0;
  logic        ResetIn_n;
  logic [1:0]  IncPCRA;
  logic        PcraFlip;
  logic        BusRequest;
  logic        FetchSurpress;
  logic [15:0] BusAddr;
  logic        LoadInactive;
  logic [15:0] LoadData;
  logic [15:0] MemAddr;
  logic        FetchValid;
  logic [15:0] ActivePc;
  logic [15:0] InactivePc;
  logic        ActiveSel;
`ifdef PCRA_FETCH_STATS_EN
  logic        StatsClear;
  logic [15:0] StallCount;
`endif

  always #5 ClockIn = ~ClockIn;

  pcra_fetch_unit #(
    .AddrWidth   (16),
    .ResetVector (16'h0000)
  ) dut (
    .ClockIn       (ClockIn),
    .ResetIn_n     (ResetIn_n),
    .IncPCRA       (IncPCRA),
    .PcraFlip      (PcraFlip),
    .BusRequest    (BusRequest),
    .FetchSurpress (FetchSurpress),
    .BusAddr       (BusAddr),
    .LoadInactive  (LoadInactive),
    .LoadData      (LoadData),
`ifdef PCRA_FETCH_STATS_EN
    .StatsClear    (StatsClear),
    .StallCount    (StallCount),
`endif
    .MemAddr       (MemAddr),
    .FetchValid    (FetchValid),
    .ActivePc      (ActivePc),
    .InactivePc    (InactivePc),
    .ActiveSel     (ActiveSel)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [15:0] mem;
    logic        fv;
  } bus_exp_t;

  typedef struct {
    string       tag;
    logic [15:0] act;
    logic [15:0] inact;
    logic        sel;
  } reg_exp_t;

  bus_exp_t q_bus[$];
  reg_exp_t q_reg[$];

`ifdef PCRA_FETCH_STATS_EN
  typedef struct {
    string       tag;
    logic [15:0] cnt;
  } stat_exp_t;
  stat_exp_t q_stat[$];

  task automatic exp_stat(input string tag, input logic [15:0] cnt);
    stat_exp_t e;
    e.tag = tag; e.cnt = cnt;
    q_stat.push_back(e);
  endtask
`endif

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic exp_bus(input string tag, input logic [15:0] mem, input logic fv);
    bus_exp_t e;
    e.tag = tag; e.mem = mem; e.fv = fv;
    q_bus.push_back(e);
  endtask

  task automatic exp_reg(input string tag, input logic [15:0] act, input logic [15:0] inact,
                         input logic sel);
    reg_exp_t e;
    e.tag = tag; e.act = act; e.inact = inact; e.sel = sel;
    q_reg.push_back(e);
  endtask

  task automatic drive(input logic rst_n, input logic [1:0] inc, input logic flip,
                       input logic breq, input logic fs, input logic [15:0] baddr,
                       input logic ld, input logic [15:0] ldata);
    ResetIn_n     = rst_n;
    IncPCRA       = inc;
    PcraFlip      = flip;
    BusRequest    = breq;
    FetchSurpress = fs;
    BusAddr       = baddr;
    LoadInactive  = ld;
    LoadData      = ldata;
  endtask

  // Runs one clock step: check combinational expectations with the current
  // inputs settled, take the edge, check registered expectations, then move
  // to the falling edge ready for the next drive.
  task automatic cyc();
    #1;
    while (q_bus.size() > 0) begin
      bus_exp_t b;
      b = q_bus.pop_front();
      cmp({b.tag, ".mem"}, MemAddr, b.mem);
      cmp({b.tag, ".fv"}, {15'b0, FetchValid}, {15'b0, b.fv});
    end
    @(posedge ClockIn);
    #1;
    while (q_reg.size() > 0) begin
      reg_exp_t r;
      r = q_reg.pop_front();
      cmp({r.tag, ".act"}, ActivePc, r.act);
      cmp({r.tag, ".inact"}, InactivePc, r.inact);
      cmp({r.tag, ".sel"}, {15'b0, ActiveSel}, {15'b0, r.sel});
    end
`ifdef PCRA_FETCH_STATS_EN
    while (q_stat.size() > 0) begin
      stat_exp_t s;
      s = q_stat.pop_front();
      cmp({s.tag, ".stall"}, StallCount, s.cnt);
    end
`endif
    @(negedge ClockIn);
  endtask

  initial begin
`ifdef PCRA_FETCH_STATS_EN
    StatsClear = 1'b0;
`endif
    // Reset, held for two edges, with noise on the other inputs.
    drive(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h5555);
    cyc();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    exp_reg("reset", 16'h0000, 16'h0000, 1'b0);
    cyc();

    // Sequential fetch.
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    exp_bus("seq0", 16'h0000, 1'b1); exp_reg("seq0", 16'h0001, 16'h0000, 1'b0); cyc();
    exp_bus("seq1", 16'h0001, 1'b1); exp_reg("seq1", 16'h0002, 16'h0000, 1'b0); cyc();
    exp_bus("seq2", 16'h0002, 1'b1); exp_reg("seq2", 16'h0003, 16'h0000, 1'b0); cyc();
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    exp_bus("seq3", 16'h0003, 1'b1); exp_reg("seq3", 16'h0003, 16'h0000, 1'b0); cyc();

    // Jump to FFFF (load + flip), then wrap.
    drive(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF);
    exp_reg("jmpffff", 16'hFFFF, 16'h0003, 1'b1); cyc();
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    exp_bus("wrap", 16'hFFFF, 1'b1); exp_reg("wrap", 16'h0000, 16'h0003, 1'b1); cyc();

    // Call: load + flip + increment in one cycle.
    drive(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0123);
    exp_reg("jmp0123", 16'h0123, 16'h0000, 1'b0); cyc();
    drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h8000);
    exp_bus("call", 16'h0123, 1'b1); exp_reg("call", 16'h8000, 16'h0124, 1'b1); cyc();
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    exp_bus("callmem", 16'h8000, 1'b1); cyc();

    // Bus arbitration.
    drive(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0010);
    exp_reg("jmp0010", 16'h0010, 16'h8000, 1'b0); cyc();
    drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 16'h4567, 1'b0, 16'h0000);
    exp_bus("busreq", 16'h4567, 1'b0); exp_reg("busreq", 16'h0010, 16'h8000, 1'b0); cyc();
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h4567, 1'b0, 16'h0000);
    exp_bus("busrel", 16'h0010, 1'b1); cyc();

    // Increments are not hidden by BusRequest or FetchSurpress.
    drive(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 16'h4567, 1'b0, 16'h0000);
    exp_bus("incbus", 16'h4567, 1'b0); exp_reg("incbus", 16'h0011, 16'h8000, 1'b0); cyc();
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000);
    exp_bus("incsup", 16'h0011, 1'b0); exp_reg("incsup", 16'h0012, 16'h8000, 1'b0); cyc();

    // Inactive increment, load beats increment, both increments.
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    exp_reg("incinact", 16'h0012, 16'h8001, 1'b0); cyc();
    drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234);
    exp_reg("ldbeats", 16'h0013, 16'h1234, 1'b0); cyc();
    drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    exp_reg("incboth", 16'h0014, 16'h1235, 1'b0); cyc();

    // Reset mid-operation with a flip pending.
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h00AA);
    exp_reg("ld00aa", 16'h0014, 16'h00AA, 1'b0); cyc();
    drive(1'b0, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777);
    exp_reg("midrst", 16'h0000, 16'h0000, 1'b0);
`ifdef PCRA_FETCH_STATS_EN
    exp_stat("midrst", 16'h0000);
`endif
    cyc();
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    exp_bus("postrst", 16'h0000, 1'b1); exp_reg("postrst", 16'h0000, 16'h0000, 1'b0); cyc();

`ifdef PCRA_FETCH_STATS_EN
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000);
    for (int i = 1; i <= 5; i++) begin
      exp_stat("stall5", 16'(i));
      cyc();
    end
    StatsClear = 1'b1;
    exp_stat("clear", 16'h0000); cyc();
    StatsClear = 1'b0;
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
    exp_stat("noinc", 16'h0000); cyc();
    drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
    repeat (65540) @(posedge ClockIn);
    @(negedge ClockIn);
    exp_stat("sat", 16'hFFFF); cyc();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
